piso_shift_controller: RTL and testbench

- Sequencer that accepts a parallel word over a valid/ready handshake, holds it in an internal parallel-load register, and shifts it out serially one bit per enabled clock.
- Signals completion with a one-cycle done pulse.
- Sits between a parallel producer (e.g. a PIPO-register output bus) and a serial consumer.
- Owns the FSM and the bit counter; the consumer may stall shifting with a pause input.

---
 rtl/piso_shift_controller.sv | 82 ++++++++
 tb/tb_piso_shift_controller.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/piso_shift_controller.sv
// Parallel-in / serial-out sequencer: accepts a word on a valid/ready
// handshake and shifts it out one bit per unpaused clock, then pulses done.
module piso_shift_controller #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pi,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             pause,
    output logic             so,
    output logic             so_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sreg_d  = pi;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!pause) begin
                    if (MSB_FIRST) sreg_d = sreg_q << 1;
                    else           sreg_d = sreg_q >> 1;
                    // Counter clears on the last bit so it never passes WIDTH-1.
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign out_bit  = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q == SHIFT) || (state_q == DONE);
    assign done     = (state_q == DONE);
    assign so       = (state_q == SHIFT) ? out_bit : 1'b0;
    assign so_valid = (state_q == SHIFT) && !pause;

endmodule

// File: tb/tb_piso_shift_controller.sv
// Directed bench for piso_shift_controller: vector table plus hand-written
// sequences for reset, back-to-back and LSB-first behaviour.
module tb_piso_shift_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pi;
    logic       in_valid;
    logic       pause;
    logic       in_ready, so, so_valid, busy, done;

    logic       iv_l;
    logic       rdy_l, so_l, sov_l, busy_l, done_l;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    piso_shift_controller #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .pi(pi), .in_valid(in_valid),
        .in_ready(in_ready), .pause(pause), .so(so),
        .so_valid(so_valid), .busy(busy), .done(done)
    );

    piso_shift_controller #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .pi(pi), .in_valid(iv_l),
        .in_ready(rdy_l), .pause(pause), .so(so_l),
        .so_valid(sov_l), .busy(busy_l), .done(done_l)
    );

    // Packed output order: {in_ready, so, so_valid, busy, done}
    typedef struct {
        logic       rst;
        logic       iv;
        logic [3:0] pi;
        logic       pause;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];

    localparam logic [4:0] O_IDLE = 5'b10000;
    localparam logic [4:0] O_S1   = 5'b01110;
    localparam logic [4:0] O_S0   = 5'b00110;
    localparam logic [4:0] O_P0   = 5'b00010;
    localparam logic [4:0] O_DONE = 5'b00011;

    function automatic logic [4:0] msb_out();
        return {in_ready, so, so_valid, busy, done};
    endfunction

    function automatic logic [4:0] lsb_out();
        return {rdy_l, so_l, sov_l, busy_l, done_l};
    endfunction

    task automatic cmp(input string nm, input logic [4:0] act,
                       input logic [4:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got {rdy,so,sov,busy,done}=%b expected %b",
                      nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic v, input logic [3:0] p,
                       input logic ps, input logic [4:0] e);
        vec_t t;
        t.rst = r; t.iv = v; t.pi = p; t.pause = ps; t.exp = e;
        tbl.push_back(t);
    endtask

    task automatic step_msb(input string nm, input logic [4:0] e);
        #1;
        cmp(nm, msb_out(), e);
        tick();
    endtask

    task automatic step_lsb(input string nm, input logic [4:0] e);
        #1;
        cmp(nm, lsb_out(), e);
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; pi = 4'b1101; pause = 1'b0; iv_l = 1'b0;
        tick();

        // Reset held with in_valid high: nothing accepted.
        for (int i = 0; i < 5; i++) add(1, 1, 4'b1101, 0, O_IDLE);
        // MSB-first 1101.
        add(0, 1, 4'b1101, 0, O_IDLE);
        add(0, 0, 4'b1101, 0, O_S1);
        add(0, 0, 4'b1101, 0, O_S1);
        add(0, 0, 4'b1101, 0, O_S0);
        add(0, 0, 4'b1101, 0, O_S1);
        add(0, 0, 4'b1101, 0, O_DONE);
        // 1000 with a pause on bit 1; pi change after accept is ignored.
        add(0, 1, 4'b1000, 0, O_IDLE);
        add(0, 0, 4'b1101, 0, O_S1);
        add(0, 0, 4'b1101, 1, O_P0);
        add(0, 0, 4'b1101, 0, O_S0);
        add(0, 0, 4'b1101, 0, O_S0);
        add(0, 0, 4'b1101, 0, O_S0);
        add(0, 0, 4'b1101, 0, O_DONE);
        add(0, 0, 4'b1101, 0, O_IDLE);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; in_valid = tbl[i].iv;
            pi = tbl[i].pi; pause = tbl[i].pause;
            step_msb($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Reset after the 2nd bit: word dropped, no done pulse.
        rst = 0; pause = 0; in_valid = 1; pi = 4'b1101;
        step_msb("rstmid_idle", O_IDLE);
        in_valid = 0;
        step_msb("rstmid_b0", O_S1);
        step_msb("rstmid_b1", O_S1);
        rst = 1;
        step_msb("rstmid_b2", O_S0);
        rst = 0; in_valid = 1; pi = 4'b1000;
        step_msb("rstmid_after", O_IDLE);
        in_valid = 0;
        step_msb("rstnew_b0", O_S1);
        step_msb("rstnew_b1", O_S0);
        step_msb("rstnew_b2", O_S0);
        step_msb("rstnew_b3", O_S0);
        step_msb("rstnew_done", O_DONE);
        step_msb("rstnew_idle", O_IDLE);

        // in_valid held high; pi changes mid-word; back-to-back accept.
        in_valid = 1; pi = 4'b1101;
        step_msb("b2b_acc1", O_IDLE);
        step_msb("b2b_w1b0", O_S1);
        pi = 4'b1000;
        step_msb("b2b_w1b1", O_S1);
        step_msb("b2b_w1b2", O_S0);
        step_msb("b2b_w1b3", O_S1);
        step_msb("b2b_w1done", O_DONE);
        step_msb("b2b_acc2", O_IDLE);
        in_valid = 0;
        step_msb("b2b_w2b0", O_S1);
        step_msb("b2b_w2b1", O_S0);
        step_msb("b2b_w2b2", O_S0);
        step_msb("b2b_w2b3", O_S0);
        step_msb("b2b_w2done", O_DONE);
        step_msb("b2b_idle", O_IDLE);

        // LSB-first instance: 1101 -> 1,0,1,1.
        iv_l = 1; pi = 4'b1101;
        step_lsb("lsb_acc", O_IDLE);
        iv_l = 0; pi = 4'b0000;
        step_lsb("lsb_b0", O_S1);
        step_lsb("lsb_b1", O_S0);
        step_lsb("lsb_b2", O_S1);
        step_lsb("lsb_b3", O_S1);
        step_lsb("lsb_done", O_DONE);
        step_lsb("lsb_idle", O_IDLE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
